ps2_scan_sequencer: RTL and testbench

// Consumes the byte stream of the PS/2 frame receiver (DATA/DONE/Rx_error) and assembles

---
 rtl/ps2_scan_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_ps2_scan_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_sequencer.sv
// ps2_scan_sequencer
// Turns the PS/2 receiver byte stream into key events. E0 marks an extended key
// and F0 marks a key release. The block strips those prefixes and queues one
// {EXT, BRK, CODE} event per key in a small first-word-fall-through FIFO.
// It also counts protocol errors, prefix timeouts and receiver parity errors.
// A sticky flag records events that were dropped because the queue was full.
module ps2_scan_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 50000
) (
  input  logic       CLKOUT,
  input  logic       RESET,
  input  logic [7:0] RX_DATA,
  input  logic       RX_DONE,
  input  logic       RX_ERR,
  output logic [9:0] EV_DATA,
  output logic       EV_VALID,
  input  logic       EV_READY,
  output logic [7:0] ERR_CNT,
  output logic       OVF,
  input  logic       OVF_CLR
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_E0   = 2'd1,
    ST_F0   = 2'd2,
    ST_E0F0 = 2'd3
  } state_t;

  state_t          state_r, state_nx_s;
  logic [TW-1:0]   tmr_r, tmr_nx_s;
  logic            done_q_r, err_q_r;
  logic            byte_stb_s, err_stb_s;
  logic            push_s, err_evt_s;
  logic [9:0]      push_data_s;
  logic [7:0]      err_cnt_r;
  logic            ovf_r;

  logic [9:0]      mem_r [DEPTH];
  logic [AW-1:0]   wr_r, rd_r, rd_nx_s;
  logic [AW:0]     count_r, count_nx_s, left_s;
  logic [9:0]      head_r, head_nx_s;
  logic            valid_r;
  logic            pop_s, full_s, wr_en_s, ovf_set_s;

  // A byte or error is the rising edge of the receiver level. The edge flops
  // reset high, so a level still high at reset release is not taken as new.
  assign byte_stb_s = RX_DONE & ~done_q_r;
  assign err_stb_s  = RX_ERR & ~err_q_r;

  // Edge-detect history for the receiver done and error levels
  always_ff @(posedge CLKOUT or posedge RESET) begin
    if (RESET) begin
      done_q_r <= 1'b1;
      err_q_r  <= 1'b1;
    end else begin
      done_q_r <= RX_DONE;
      err_q_r  <= RX_ERR;
    end
  end

  // Prefix FSM: next state, event push, error detection and prefix timer
  always_comb begin
    state_nx_s  = state_r;
    push_s      = 1'b0;
    push_data_s = {2'b00, RX_DATA};
    err_evt_s   = 1'b0;
    tmr_nx_s    = tmr_r;
    if (err_stb_s) begin
      // a parity error discards any pending prefix and ignores a coincident byte
      state_nx_s = ST_IDLE;
      err_evt_s  = 1'b1;
    end else if (byte_stb_s) begin
      case (state_r)
        ST_IDLE: begin
          if (RX_DATA == 8'hE0) begin
            state_nx_s = ST_E0;
          end else if (RX_DATA == 8'hF0) begin
            state_nx_s = ST_F0;
          end else begin
            push_s      = 1'b1;
            push_data_s = {2'b00, RX_DATA};
          end
        end
        ST_E0: begin
          if (RX_DATA == 8'hF0) begin
            state_nx_s = ST_E0F0;
          end else if (RX_DATA == 8'hE0) begin
            state_nx_s = ST_E0;
          end else begin
            push_s      = 1'b1;
            push_data_s = {2'b10, RX_DATA};
            state_nx_s  = ST_IDLE;
          end
        end
        ST_F0: begin
          if ((RX_DATA == 8'hE0) || (RX_DATA == 8'hF0)) begin
            err_evt_s  = 1'b1;
            state_nx_s = ST_IDLE;
          end else begin
            push_s      = 1'b1;
            push_data_s = {2'b01, RX_DATA};
            state_nx_s  = ST_IDLE;
          end
        end
        ST_E0F0: begin
          if ((RX_DATA == 8'hE0) || (RX_DATA == 8'hF0)) begin
            err_evt_s  = 1'b1;
            state_nx_s = ST_IDLE;
          end else begin
            push_s      = 1'b1;
            push_data_s = {2'b11, RX_DATA};
            state_nx_s  = ST_IDLE;
          end
        end
        default: begin
          state_nx_s = ST_IDLE;
        end
      endcase
    end else if ((state_r != ST_IDLE) && (tmr_r == TMR_LAST)) begin
      // the completing byte did not arrive in time
      state_nx_s = ST_IDLE;
      err_evt_s  = 1'b1;
    end else begin
      state_nx_s = state_r;
    end

    // the timer only runs while a prefix waits, and each byte restarts it
    if (byte_stb_s || err_stb_s || (state_nx_s == ST_IDLE)) begin
      tmr_nx_s = {TW{1'b0}};
    end else begin
      tmr_nx_s = tmr_r + TW'(1);
    end
  end

  // FSM state and prefix timer registers
  always_ff @(posedge CLKOUT or posedge RESET) begin
    if (RESET) begin
      state_r <= ST_IDLE;
      tmr_r   <= {TW{1'b0}};
    end else begin
      state_r <= state_nx_s;
      tmr_r   <= tmr_nx_s;
    end
  end

  // Saturating error counter; coincident causes count once
  always_ff @(posedge CLKOUT or posedge RESET) begin
    if (RESET) begin
      err_cnt_r <= 8'd0;
    end else if (err_evt_s && (err_cnt_r != 8'hFF)) begin
      err_cnt_r <= err_cnt_r + 8'd1;
    end
  end

  // FIFO control: accept a push when there is room or the head leaves this cycle
  always_comb begin
    pop_s      = valid_r & EV_READY;
    full_s     = (count_r == FULL_CNT);
    wr_en_s    = push_s & (~full_s | pop_s);
    ovf_set_s  = push_s & full_s & ~pop_s;
    rd_nx_s    = pop_s ? (rd_r + AW'(1)) : rd_r;
    left_s     = count_r - (AW + 1)'(pop_s);
    count_nx_s = count_r;
    case ({wr_en_s, pop_s})
      2'b10:   count_nx_s = count_r + (AW + 1)'(1);
      2'b01:   count_nx_s = count_r - (AW + 1)'(1);
      default: count_nx_s = count_r;
    endcase
    // The registered head comes from the incoming event when the queue would
    // otherwise be empty. In all other cases it comes from the next stored slot.
    if (left_s == (AW + 1)'(0)) begin
      if (wr_en_s) begin
        head_nx_s = push_data_s;
      end else begin
        head_nx_s = 10'd0;
      end
    end else begin
      head_nx_s = mem_r[rd_nx_s];
    end
  end

  // FIFO storage, pointers, registered head and valid
  always_ff @(posedge CLKOUT or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 10'd0;
      end
      wr_r    <= {AW{1'b0}};
      rd_r    <= {AW{1'b0}};
      count_r <= {(AW + 1){1'b0}};
      head_r  <= 10'd0;
      valid_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_r] <= push_data_s;
        wr_r        <= wr_r + AW'(1);
      end
      rd_r    <= rd_nx_s;
      count_r <= count_nx_s;
      head_r  <= head_nx_s;
      valid_r <= (count_nx_s != (AW + 1)'(0));
    end
  end

  // Sticky overflow flag; a new drop wins over a clear in the same cycle
  always_ff @(posedge CLKOUT or posedge RESET) begin
    if (RESET) begin
      ovf_r <= 1'b0;
    end else if (ovf_set_s) begin
      ovf_r <= 1'b1;
    end else if (OVF_CLR) begin
      ovf_r <= 1'b0;
    end
  end

  assign EV_DATA  = head_r;
  assign EV_VALID = valid_r;
  assign ERR_CNT  = err_cnt_r;
  assign OVF      = ovf_r;

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// Directed bench for ps2_scan_sequencer.
// It uses a small timeout so the prefix timeout fires within a few cycles.
module tb_ps2_scan_sequencer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 20;

  logic       CLKOUT = 1'b0;
  logic       RESET;
  logic [7:0] RX_DATA;
  logic       RX_DONE;
  logic       RX_ERR;
  logic [9:0] EV_DATA;
  logic       EV_VALID;
  logic       EV_READY;
  logic [7:0] ERR_CNT;
  logic       OVF;
  logic       OVF_CLR;

  int n_chk  = 0;
  int n_fail = 0;

  ps2_scan_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .CLKOUT  (CLKOUT),
    .RESET   (RESET),
    .RX_DATA (RX_DATA),
    .RX_DONE (RX_DONE),
    .RX_ERR  (RX_ERR),
    .EV_DATA (EV_DATA),
    .EV_VALID(EV_VALID),
    .EV_READY(EV_READY),
    .ERR_CNT (ERR_CNT),
    .OVF     (OVF),
    .OVF_CLR (OVF_CLR)
  );

  always #5 CLKOUT = ~CLKOUT;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // called at a negedge, returns at a negedge with the byte's event visible
  task automatic send(input logic [7:0] b);
    RX_DATA = b;
    RX_DONE = 1'b1;
    @(negedge CLKOUT);
    RX_DONE = 1'b0;
    @(negedge CLKOUT);
  endtask

  // called at a negedge: checks the head, pops it, returns at a negedge
  task automatic pop_expect(input string tag, input logic [9:0] exp);
    check_val({tag, "_valid"}, {31'd0, EV_VALID}, 32'd1);
    check_val({tag, "_data"}, {22'd0, EV_DATA}, {22'd0, exp});
    EV_READY = 1'b1;
    @(negedge CLKOUT);
    EV_READY = 1'b0;
  endtask

  initial begin
    RESET    = 1'b1;
    RX_DATA  = 8'h00;
    RX_DONE  = 1'b0;
    RX_ERR   = 1'b0;
    EV_READY = 1'b0;
    OVF_CLR  = 1'b0;
    repeat (2) @(negedge CLKOUT);
    check_val("rst_valid", {31'd0, EV_VALID}, 32'd0);
    check_val("rst_data", {22'd0, EV_DATA}, 32'd0);
    check_val("rst_errcnt", {24'd0, ERR_CNT}, 32'd0);
    check_val("rst_ovf", {31'd0, OVF}, 32'd0);
    RESET = 1'b0;
    @(negedge CLKOUT);

    // plain make code, including the one-cycle latency
    RX_DATA = 8'h1C;
    RX_DONE = 1'b1;
    check_val("make_pre_valid", {31'd0, EV_VALID}, 32'd0);
    @(posedge CLKOUT);
    #1;
    check_val("make_lat_valid", {31'd0, EV_VALID}, 32'd1);
    @(negedge CLKOUT);
    RX_DONE = 1'b0;
    @(negedge CLKOUT);
    check_val("make_errcnt", {24'd0, ERR_CNT}, 32'd0);
    pop_expect("make", 10'h01C);
    check_val("make_empty", {31'd0, EV_VALID}, 32'd0);

    // an error and a byte on the same edge: the error wins and the byte is dropped
    RX_DATA = 8'h2A;
    RX_DONE = 1'b1;
    RX_ERR  = 1'b1;
    @(negedge CLKOUT);
    RX_DONE = 1'b0;
    RX_ERR  = 1'b0;
    @(negedge CLKOUT);
    check_val("prio_valid", {31'd0, EV_VALID}, 32'd0);
    check_val("prio_errcnt", {24'd0, ERR_CNT}, 32'd1);

    // extended break E0 F0 75
    send(8'hE0);
    check_val("ext_e0_valid", {31'd0, EV_VALID}, 32'd0);
    send(8'hF0);
    check_val("ext_f0_valid", {31'd0, EV_VALID}, 32'd0);
    send(8'h75);
    pop_expect("extbrk", 10'h375);
    check_val("extbrk_empty", {31'd0, EV_VALID}, 32'd0);

    // a parity error after F0 discards the prefix
    send(8'hF0);
    RX_ERR = 1'b1;
    @(negedge CLKOUT);
    RX_ERR = 1'b0;
    @(negedge CLKOUT);
    check_val("rxerr_errcnt", {24'd0, ERR_CNT}, 32'd2);
    send(8'h1C);
    pop_expect("rxerr_next", 10'h01C);
    check_val("rxerr_empty", {31'd0, EV_VALID}, 32'd0);

    // prefix timeout after E0: it must not fire early and must fire at TIMEOUT
    send(8'hE0);
    repeat (TIMEOUT - 3) @(negedge CLKOUT);
    check_val("tmo_early", {24'd0, ERR_CNT}, 32'd2);
    repeat (3) @(negedge CLKOUT);
    check_val("tmo_errcnt", {24'd0, ERR_CNT}, 32'd3);
    send(8'h75);
    pop_expect("tmo_next", 10'h075);

    // queue overflow, simultaneous push and pop when full, OVF clear, drain order
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send(8'h44);
    check_val("full_noovf", {31'd0, OVF}, 32'd0);
    send(8'h55);
    check_val("ovf_set", {31'd0, OVF}, 32'd1);
    check_val("ovf_head", {22'd0, EV_DATA}, 32'h011);
    RX_DATA  = 8'h66;
    RX_DONE  = 1'b1;
    EV_READY = 1'b1;
    @(negedge CLKOUT);
    RX_DONE  = 1'b0;
    EV_READY = 1'b0;
    @(negedge CLKOUT);
    OVF_CLR = 1'b1;
    @(negedge CLKOUT);
    OVF_CLR = 1'b0;
    check_val("ovf_clr", {31'd0, OVF}, 32'd0);
    pop_expect("drain0", 10'h022);
    pop_expect("drain1", 10'h033);
    pop_expect("drain2", 10'h044);
    pop_expect("drain3", 10'h066);
    check_val("drain_empty", {31'd0, EV_VALID}, 32'd0);

    // reset mid-sequence with RX_DONE held high across the release
    send(8'h1C);
    send(8'hE0);
    RX_DATA = 8'h3B;
    RX_DONE = 1'b1;
    RESET   = 1'b1;
    @(negedge CLKOUT);
    check_val("mrst_valid", {31'd0, EV_VALID}, 32'd0);
    check_val("mrst_errcnt", {24'd0, ERR_CNT}, 32'd0);
    RESET = 1'b0;
    repeat (3) @(negedge CLKOUT);
    check_val("hold_valid", {31'd0, EV_VALID}, 32'd0);
    RX_DONE = 1'b0;
    @(negedge CLKOUT);
    send(8'h75);
    pop_expect("mrst_next", 10'h075);

    // error counter saturation with F0,F0 pairs
    for (int i = 0; i < 255; i++) begin
      send(8'hF0);
      send(8'hF0);
    end
    check_val("sat_255", {24'd0, ERR_CNT}, 32'd255);
    send(8'hF0);
    send(8'hF0);
    check_val("sat_hold", {24'd0, ERR_CNT}, 32'd255);
    check_val("sat_valid", {31'd0, EV_VALID}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
